pe_column_conv: RTL
===================

Name: pe_column_conv

Overview:
- Parametrised successor of the fixed 3-row PE column.
- Each of ROWS rows keeps a TAPS-deep sliding window of an unsigned ifmap stream and multiplies it against a TAPS-weight word; all row products are summed into one column partial sum.
- Optional bias, window stride and activation mode are added on top of the sum.
- Sits in the PE array between the ifmap/weight feeders and the output writeback; forwards ifmap taps and weights to the neighbouring column.

Parameters:
- ROWS, 3, number of PE rows (kernel height), >=1
- TAPS, 3, window taps per row (kernel width), >=1
- DW, 8, ifmap sample width, unsigned
- WW, 4, weight width, unsigned
- PSW, 16, partial-sum width; saturating
- SW, 2, stride field width

Ports:
- clk  in  1  PE clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global advance; 0 freezes every register
- in_valid  in  1  ifmap/weight sample valid
- line_start  in  1  qualifies in_valid; marks the first sample of a line
- ifmap_in  in  ROWS*DW  one sample per row; row r = bits [r*DW +: DW]
- filtr_in  in  ROWS*TAPS*WW  weights; row r tap t = [(r*TAPS+t)*WW +: WW]; tap 0 pairs with the newest sample
- bias  in  PSW  unsigned bias added to each window sum
- stride  in  SW  output every stride-th window; 0 is treated as 1
- act_mode  in  1  0 = clip, 1 = piecewise compress
- ifmap_shift_out  out  (ROWS-1)*DW  oldest tap of rows 0..ROWS-2, for the next column
- filtr_out  out  ROWS*TAPS*WW  filtr_in registered on each accepted sample
- out_valid  out  1  result valid
- psum_out  out  PSW  saturated window sum plus bias
- act_out  out  8  activated result

Behaviour:
- Accept condition: acc = en & in_valid. When en=0, all state holds and out_valid holds its value.
- Reset: all tap registers, filtr_out, pipeline registers, fill_cnt, stride_cnt, psum_out, act_out and out_valid clear to 0. Reset is asynchronous and may assert mid-line; after release, the stream restarts with no output until a full window is refilled.
- Taps: on acc, each row shifts: tap0 <= ifmap_in row, tap t <= tap t-1. Weights are captured into an internal weight register alongside.
- fill_cnt, saturating at TAPS:
  - on acc with line_start: fill_cnt <= 1;
  - on acc otherwise: fill_cnt <= min(fill_cnt+1, TAPS).
  - The window is complete on an accepted sample that makes fill_cnt equal TAPS.
- stride_cnt: cleared on acc&line_start. On each complete window: emit = (stride_cnt==0); stride_cnt <= (stride_cnt+1 == eff_stride) ? 0 : stride_cnt+1.
- Pipeline, each stage advancing only when en=1:
  - S1: register the ROWS row products, each the sum over t of tap_t*w_t at full width; carries the valid bit (complete & emit).
  - S2: adder tree across rows plus bias, saturating to 2^PSW-1.
  - S3: psum_out, act_out and out_valid registered.
- Latency: out_valid rises 3 en=1 cycles after the edge that accepted the window-completing sample; with en held high, 3 clocks. A bubble (in_valid=0) propagates as out_valid=0.
- Activation, applied to s = psum_out value:
  - act_mode 0: s>255 ? 255 : s.
  - act_mode 1: s<64 gives s; 64<=s<2048 gives 64+((s-64)>>4); s>=2048 gives min(188+((s-2048)>>8), 255).
  - The curve is monotonic and continuous at 2048 (187 to 188).
- bias, stride and act_mode are sampled at the S1/S2 stage entry alongside the data; changes apply from the next accepted sample.
- line_start together with a partial window discards the partial window, with no output from it.

Test Plan:
- Reset, then ROWS*3 samples: x=1, w=1, line_start on the first, bias=0, stride=1, act_mode=0 -> first out_valid 3 clocks after the 3rd accept; psum_out=9, act_out=9; one output per sample thereafter.
- x=10, w=2, act_mode=1 -> psum_out=180, act_out=71. Repeat with bias=2000 -> psum 2180, act_out=188.
- x=255, w=15, bias=0xFFFF -> psum_out saturates to 65535, act_out=255 (both modes).
- stride=2, 6 accepted samples with line_start on the first -> windows at samples 3..6; outputs only for samples 3 and 5.
- en=0 for 4 cycles mid-stream with in_valid=1 -> no state change and out_valid held; resumes with identical results and a total of 3 en=1 cycles of latency.
- rst_n pulsed low mid-line, then stream resumes without line_start -> all outputs 0 during reset; first out_valid only after 3 fresh accepts.
- line_start after 2 samples -> partial window dropped; ifmap_shift_out equals each row's oldest tap after every accept.

Source files
------------

// File: rtl/pe_column_conv_if.sv
// Bundle of the PE column's data/control signals. The feeder and writeback side
// uses the master modport; the column itself uses the slave modport.
interface pe_column_conv_if #(
  parameter int ROWS = 3,
  parameter int TAPS = 3,
  parameter int DW   = 8,
  parameter int WW   = 4,
  parameter int PSW  = 16,
  parameter int SW   = 2
) ();
  logic                       en;
  logic                       in_valid;
  logic                       line_start;
  logic [ROWS*DW-1:0]         ifmap_in;
  logic [ROWS*TAPS*WW-1:0]    filtr_in;
  logic [PSW-1:0]             bias;
  logic [SW-1:0]              stride;
  logic                       act_mode;
  logic [(ROWS-1)*DW-1:0]     ifmap_shift_out;
  logic [ROWS*TAPS*WW-1:0]    filtr_out;
  logic                       out_valid;
  logic [PSW-1:0]             psum_out;
  logic [7:0]                 act_out;

  modport master (
    output en, in_valid, line_start, ifmap_in, filtr_in, bias, stride, act_mode,
    input  ifmap_shift_out, filtr_out, out_valid, psum_out, act_out
  );

  modport slave (
    input  en, in_valid, line_start, ifmap_in, filtr_in, bias, stride, act_mode,
    output ifmap_shift_out, filtr_out, out_valid, psum_out, act_out
  );
endinterface

// File: rtl/pe_column_conv.sv
// Parametrised PE column: ROWS rows of TAPS-deep sliding windows, each dotted
// with its weight row; row products are summed with a bias, saturated to PSW
// bits and passed through a clip or piecewise-compress activation.
// Window capture, then three pipeline stages (products, sum, output).
module pe_column_conv #(
  parameter int ROWS = 3,
  parameter int TAPS = 3,
  parameter int DW   = 8,
  parameter int WW   = 4,
  parameter int PSW  = 16,
  parameter int SW   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_column_conv_if.slave bus
);
  localparam int FW   = $clog2(TAPS + 1);
  localparam int PW   = DW + WW + $clog2(TAPS + 1);
  localparam int SUMW = ((PSW > PW + $clog2(ROWS + 1)) ? PSW : PW + $clog2(ROWS + 1)) + 1;

  function automatic logic [PSW-1:0] sat_psum(input logic [SUMW-1:0] v);
    if (|v[SUMW-1:PSW]) return '1;
    return v[PSW-1:0];
  endfunction

  function automatic logic [7:0] act_fn(input logic [PSW-1:0] s, input logic mode);
    logic [31:0] x;
    logic [31:0] y;
    x = 32'(s);
    if (!mode)              y = (x > 32'd255) ? 32'd255 : x;
    else if (x < 32'd64)    y = x;
    else if (x < 32'd2048)  y = 32'd64 + ((x - 32'd64) >> 4);
    else begin
      y = 32'd188 + ((x - 32'd2048) >> 8);
      if (y > 32'd255) y = 32'd255;
    end
    return y[7:0];
  endfunction

  logic                    acc;
  logic                    complete;
  logic [SW:0]             eff_stride;
  logic [SW:0]             scnt_base;
  logic [SW:0]             scnt_inc;
  logic [FW-1:0]           fill_q, fill_d;
  logic [SW-1:0]           scnt_q, scnt_d;
  logic                    vld_p0_q, vld_p0_d;
  logic [PSW-1:0]          bias_p0_q;
  logic                    mode_p0_q;
  logic [DW-1:0]           tap_q [ROWS][TAPS];
  logic [ROWS*TAPS*WW-1:0] w_q;

  logic [PW-1:0]           rowp_d    [ROWS];
  logic [PW-1:0]           rowp_p1_q [ROWS];
  logic [PSW-1:0]          bias_p1_q;
  logic                    mode_p1_q;
  logic                    vld_p1_q;

  logic [SUMW-1:0]         sum_d;
  logic [PSW-1:0]          sum_p2_q;
  logic                    mode_p2_q;
  logic                    vld_p2_q;

  logic [PSW-1:0]          psum_q;
  logic [7:0]              act_q;
  logic                    ovld_q;

  // Window fill / stride bookkeeping; a line_start restarts both counters.
  always_comb begin
    acc        = bus.en & bus.in_valid;
    eff_stride = (bus.stride == '0) ? (SW+1)'(1) : {1'b0, bus.stride};
    fill_d     = fill_q;
    scnt_d     = scnt_q;
    scnt_base  = {1'b0, scnt_q};
    scnt_inc   = '0;
    complete   = 1'b0;
    vld_p0_d   = 1'b0;
    if (acc) begin
      if (bus.line_start) begin
        fill_d    = FW'(1);
        scnt_base = '0;
      end else if (fill_q != FW'(TAPS)) begin
        fill_d = fill_q + FW'(1);
      end
      complete = (fill_d == FW'(TAPS));
      scnt_inc = scnt_base + (SW+1)'(1);
      if (complete) begin
        vld_p0_d = (scnt_base == '0);
        scnt_d   = (scnt_inc >= eff_stride) ? '0 : scnt_inc[SW-1:0];
      end else begin
        scnt_d   = scnt_base[SW-1:0];
      end
    end
  end

  // Control state; a bubble (en=1, no accept) clears the window-valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q   <= '0;
      scnt_q   <= '0;
      vld_p0_q <= 1'b0;
    end else if (bus.en) begin
      fill_q   <= fill_d;
      scnt_q   <= scnt_d;
      vld_p0_q <= vld_p0_d;
    end
  end

  // Tap shift and weight/bias/mode capture on every accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int t = 0; t < TAPS; t++)
          tap_q[r][t] <= '0;
      w_q       <= '0;
      bias_p0_q <= '0;
      mode_p0_q <= 1'b0;
    end else if (acc) begin
      for (int r = 0; r < ROWS; r++) begin
        tap_q[r][0] <= bus.ifmap_in[r*DW +: DW];
        for (int t = 1; t < TAPS; t++)
          tap_q[r][t] <= tap_q[r][t-1];
      end
      w_q       <= bus.filtr_in;
      bias_p0_q <= bus.bias;
      mode_p0_q <= bus.act_mode;
    end
  end

  // ---- S1: per-row dot products at full width ----
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      rowp_d[r] = '0;
      for (int t = 0; t < TAPS; t++)
        rowp_d[r] = rowp_d[r] + PW'(tap_q[r][t]) * PW'(w_q[(r*TAPS+t)*WW +: WW]);
    end
  end

  // ---- S2: row adder tree plus bias, saturated ----
  always_comb begin
    sum_d = SUMW'(bias_p1_q);
    for (int r = 0; r < ROWS; r++)
      sum_d = sum_d + SUMW'(rowp_p1_q[r]);
  end

  // Pipeline S1 -> S2 -> S3, frozen while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) rowp_p1_q[r] <= '0;
      bias_p1_q <= '0;
      mode_p1_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      sum_p2_q  <= '0;
      mode_p2_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      psum_q    <= '0;
      act_q     <= '0;
      ovld_q    <= 1'b0;
    end else if (bus.en) begin
      for (int r = 0; r < ROWS; r++) rowp_p1_q[r] <= rowp_d[r];
      bias_p1_q <= bias_p0_q;
      mode_p1_q <= mode_p0_q;
      vld_p1_q  <= vld_p0_q;
      sum_p2_q  <= sat_psum(sum_d);
      mode_p2_q <= mode_p1_q;
      vld_p2_q  <= vld_p1_q;
      // ---- S3: registered outputs ----
      psum_q    <= sum_p2_q;
      act_q     <= act_fn(sum_p2_q, mode_p2_q);
      ovld_q    <= vld_p2_q;
    end
  end

  for (genvar r = 0; r < ROWS - 1; r++) begin : g_shift
    assign bus.ifmap_shift_out[r*DW +: DW] = tap_q[r][TAPS-1];
  end

  assign bus.filtr_out = w_q;
  assign bus.out_valid = ovld_q;
  assign bus.psum_out  = psum_q;
  assign bus.act_out   = act_q;
endmodule
